dec_host_sequencer: RTL and testbench

- Host-side controller that configures and feeds the DEC decision-tree accelerator.
- On a start command it streams the node tables from a table buffer, in order feature index (mode 0), threshold (mode 1), children (mode 2).
- It then streams feature rows from a data buffer (mode 3) and counts DEC results until every row has been classified.
- It replaces the host-side loading sequence in system integration and owns the DEC input handshake.

---
 rtl/dec_host_sequencer_if.sv | 31 +++
 rtl/dec_host_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_dec_host_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_host_sequencer_if.sv
// DEC input handshake and result strobe shared
// by the host sequencer and the accelerator.
interface dec_host_sequencer_if #(
  parameter int NUM_FEATURE = 8,
  parameter int ID_W        = 12
);
  logic                     dec_valid;
  logic [1:0]               dec_mode;
  logic [8*NUM_FEATURE-1:0] dec_data;
  logic [ID_W-1:0]          dec_id;
  logic                     dec_ready;
  logic                     dec_out_valid;

  modport master (
    output dec_valid,
    output dec_mode,
    output dec_data,
    output dec_id,
    input  dec_ready,
    input  dec_out_valid
  );

  modport slave (
    input  dec_valid,
    input  dec_mode,
    input  dec_data,
    input  dec_id,
    output dec_ready,
    output dec_out_valid
  );
endinterface

// File: rtl/dec_host_sequencer.sv
// Host sequencer: streams node tables and feature
// rows into DEC, then waits for every result.
module dec_host_sequencer #(
  parameter int NUM_FEATURE = 8,
  parameter int ID_W        = 12,
  parameter int TBL_AW      = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     cfg_load_tables,
  input  logic [7:0]               cfg_num_node,
  input  logic [ID_W-1:0]          cfg_num_data,
  output logic                     tbl_rd_en,
  output logic [TBL_AW-1:0]        tbl_addr,
  input  logic [7:0]               tbl_rdata,
  output logic                     dat_rd_en,
  output logic [ID_W-1:0]          dat_addr,
  input  logic [8*NUM_FEATURE-1:0] dat_rdata,
  dec_host_sequencer_if.master     dec,
  output logic                     busy,
  output logic                     done
);
  localparam int DW = 8*NUM_FEATURE;

  typedef enum logic [2:0] {
    IDLE, FEA, THD, CHD, DATA, DRAIN
  } state_t;

  typedef struct packed {
    logic [1:0]      mode;
    logic [DW-1:0]   data;
    logic [ID_W-1:0] id;
  } beat_t;

  state_t state, state_nxt;

  logic [7:0]        n_q;
  logic [ID_W-1:0]   d_q;
  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   res_cnt;
  logic [ID_W-1:0]   total;
  logic [TBL_AW-1:0] tbl_base;
  logic [1:0]        mode_cur;
  logic              rd_state;
  logic              issue;
  logic              last;

  logic              rf_vld;
  logic [1:0]        rf_mode;
  logic [ID_W-1:0]   rf_idx;

  beat_t             q0, q1, nb;
  logic [1:0]        cnt;
  logic              pop;
  logic [2:0]        occ;

  assign pop = (cnt != 2'd0) && dec.dec_ready;
  // occupancy at the next edge, counting the beat leaving now
  assign occ = {1'b0, cnt} + {2'b00, rf_vld}
             - {2'b00, pop};

  always_comb begin
    state_nxt = state;
    total     = '0;
    tbl_base  = '0;
    mode_cur  = 2'd0;
    rd_state  = 1'b0;
    done      = 1'b0;
    issue     = 1'b0;
    last      = 1'b0;
    unique case (state)
      FEA: begin
        total    = ID_W'(n_q);
        rd_state = 1'b1;
      end
      THD: begin
        total    = ID_W'(n_q);
        tbl_base = TBL_AW'('h100);
        mode_cur = 2'd1;
        rd_state = 1'b1;
      end
      CHD: begin
        total    = ID_W'({n_q, 1'b0});
        tbl_base = TBL_AW'('h200);
        mode_cur = 2'd2;
        rd_state = 1'b1;
      end
      DATA: begin
        total    = d_q;
        mode_cur = 2'd3;
        rd_state = 1'b1;
      end
      default: ;
    endcase
    issue = rd_state && (total != '0)
         && (occ < 3'd2);
    last  = issue && (idx == total - 1'b1);
    unique case (state)
      IDLE:
        if (start)
          state_nxt = cfg_load_tables ? FEA : DATA;
      FEA:
        if (last) state_nxt = THD;
      THD:
        if (last) state_nxt = CHD;
      CHD:
        if (last) state_nxt = DATA;
      DATA:
        if (last || total == '0)
          state_nxt = DRAIN;
      DRAIN:
        if (cnt == 2'd0 && !rf_vld
            && res_cnt == d_q) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign tbl_rd_en = issue && (state != DATA);
  assign dat_rd_en = issue && (state == DATA);
  assign tbl_addr  = tbl_rd_en
                   ? tbl_base + TBL_AW'(idx) : '0;
  assign dat_addr  = dat_rd_en ? idx : '0;

  always_comb begin
    nb      = '0;
    nb.mode = rf_mode;
    if (rf_mode == 2'd3) begin
      nb.data = dat_rdata;
      nb.id   = rf_idx;
    end else begin
      nb.data[7:0]  = tbl_rdata;
      nb.data[15:8] = rf_idx[7:0];
      if (rf_mode == 2'd2)
        nb.data[16] = rf_idx[8];
    end
  end

  assign dec.dec_valid = (cnt != 2'd0);
  assign dec.dec_mode  = q0.mode;
  assign dec.dec_data  = q0.data;
  assign dec.dec_id    = q0.id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      idx     <= '0;
      res_cnt <= '0;
      rf_vld  <= 1'b0;
      rf_mode <= 2'd0;
      rf_idx  <= '0;
      q0      <= '0;
      q1      <= '0;
      cnt     <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        n_q     <= cfg_num_node;
        d_q     <= cfg_num_data;
        res_cnt <= '0;
      end else if (busy && dec.dec_out_valid
                   && res_cnt != d_q) begin
        res_cnt <= res_cnt + 1'b1;
      end
      if (last)
        idx <= '0;
      else if (issue)
        idx <= idx + 1'b1;
      rf_vld  <= issue;
      rf_mode <= mode_cur;
      rf_idx  <= idx;
      case ({rf_vld, pop})
        2'b10: begin
          if (cnt == 2'd0) q0 <= nb;
          else             q1 <= nb;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            q0 <= nb;
          end else begin
            q0 <= q1;
            q1 <= nb;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dec_host_sequencer.sv
// Bench for dec_host_sequencer: vector table of runs
// checked against a beat scoreboard and a DEC model.
module tb_dec_host_sequencer;
  localparam int NF     = 8;
  localparam int ID_W   = 12;
  localparam int TBL_AW = 10;
  localparam int DW     = 8*NF;

  typedef struct packed {
    logic [1:0]      mode;
    logic [DW-1:0]   data;
    logic [ID_W-1:0] id;
  } beat_t;

  typedef struct {
    bit lt;
    int n;
    int d;
    int pct;
    int poke;
    int early;
    int e_m0;
    int e_m1;
    int e_m2;
    int e_m3;
    int e_tbl;
    int e_max;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cfg_load_tables = 1'b0;
  logic [7:0] cfg_num_node = '0;
  logic [ID_W-1:0] cfg_num_data = '0;
  logic tbl_rd_en, dat_rd_en, busy, done;
  logic [TBL_AW-1:0] tbl_addr;
  logic [7:0] tbl_rdata = '0;
  logic [ID_W-1:0] dat_addr;
  logic [DW-1:0] dat_rdata = '0;

  dec_host_sequencer_if #(
    .NUM_FEATURE(NF), .ID_W(ID_W)
  ) dec_if ();

  dec_host_sequencer #(
    .NUM_FEATURE(NF), .ID_W(ID_W), .TBL_AW(TBL_AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_load_tables(cfg_load_tables),
    .cfg_num_node(cfg_num_node),
    .cfg_num_data(cfg_num_data),
    .tbl_rd_en(tbl_rd_en),
    .tbl_addr(tbl_addr),
    .tbl_rdata(tbl_rdata),
    .dat_rd_en(dat_rd_en),
    .dat_addr(dat_addr),
    .dat_rdata(dat_rdata),
    .dec(dec_if),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] row_fn(
    input logic [ID_W-1:0] a);
    return {4'hC, a, ~a, a ^ 12'h5A5,
            a + 12'd77, 12'(a * 12'd3)};
  endfunction

  logic [7:0] tbl_mem [1024];

  always @(posedge clk) begin
    if (tbl_rd_en) tbl_rdata <= tbl_mem[tbl_addr];
    else           tbl_rdata <= 8'($urandom);
    if (dat_rd_en) dat_rdata <= row_fn(dat_addr);
    else           dat_rdata <= {$urandom, $urandom};
  end

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  beat_t exp_q [$];
  int pct = 100;
  int early_left = 0;
  bit mon_on = 1'b0;
  int mode_cnt [4];
  int tbl_rds, dat_rds, done_cnt;
  int first_cyc, last_xfer_cyc, done_cyc;
  logic [TBL_AW-1:0] max_addr;
  logic [7:0] dsh = '0;
  bit stall_prev = 1'b0;
  beat_t prev_b, cur_b, e_b;

  initial begin
    dec_if.dec_ready = 1'b0;
    dec_if.dec_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      dec_if.dec_ready = ($urandom_range(0, 99) < pct);
      dsh = {dsh[6:0], 1'b0};
      dec_if.dec_out_valid = dsh[4]
                          || (early_left > 0 && busy);
      if (early_left > 0 && busy) early_left--;
      #1;
      cur_b = {dec_if.dec_mode, dec_if.dec_data,
               dec_if.dec_id};
      if (!rst_n) begin
        exp_q.delete();
        dsh = '0;
        stall_prev = 1'b0;
      end else if (mon_on) begin
        if (tbl_rd_en) begin
          tbl_rds++;
          if (tbl_addr > max_addr) max_addr = tbl_addr;
        end
        if (dat_rd_en) dat_rds++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (dec_if.dec_valid && first_cyc < 0)
          first_cyc = cyc;
        if (stall_prev)
          check("stall_hold",
                {dec_if.dec_valid, cur_b},
                {1'b1, prev_b});
        if (dec_if.dec_valid && dec_if.dec_ready) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e_b = exp_q.pop_front();
            check("beat", cur_b, e_b);
          end
          mode_cnt[dec_if.dec_mode]++;
          if (dec_if.dec_mode == 2'd3) dsh[0] = 1'b1;
          last_xfer_cyc = cyc;
        end
        stall_prev = dec_if.dec_valid
                  && !dec_if.dec_ready;
        prev_b = cur_b;
      end
    end
  end

  task automatic run(input vec_t v);
    int t, budget, start_cyc;
    exp_q.delete();
    if (v.lt) begin
      for (int i = 0; i < v.n; i++)
        exp_q.push_back({2'd0, 48'd0, 8'(i),
                         tbl_mem[i], 12'd0});
      for (int i = 0; i < v.n; i++)
        exp_q.push_back({2'd1, 48'd0, 8'(i),
                         tbl_mem[256 + i], 12'd0});
      for (int i = 0; i < 2 * v.n; i++)
        exp_q.push_back({2'd2, 40'd0, 7'd0, 1'(i >> 8),
                         8'(i), tbl_mem[512 + i], 12'd0});
    end
    for (int i = 0; i < v.d; i++)
      exp_q.push_back({2'd3, row_fn(12'(i)), 12'(i)});
    for (int m = 0; m < 4; m++) mode_cnt[m] = 0;
    tbl_rds = 0;
    dat_rds = 0;
    done_cnt = 0;
    first_cyc = -1;
    last_xfer_cyc = 0;
    done_cyc = 0;
    max_addr = '0;
    stall_prev = 1'b0;
    pct = v.pct;
    mon_on = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    cfg_load_tables = v.lt;
    cfg_num_node = 8'(v.n);
    cfg_num_data = ID_W'(v.d);
    start = 1'b1;
    early_left = v.early;
    @(negedge clk);
    start = 1'b0;
    #2;
    check("busy_after_start", busy, 1);
    budget = (4 * v.n + v.d + 50)
           * ((v.pct < 50) ? 6 : 3) + 100;
    t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(negedge clk);
      t++;
      if (t == v.poke) begin
        start = 1'b1;
        cfg_load_tables = 1'b1;
        cfg_num_node = 8'd3;
        cfg_num_data = 12'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", done_cnt != 0, 1);
    #2;
    check("busy_after_done", busy, 0);
    repeat (5) @(negedge clk);
    #2;
    check("done_once", done_cnt, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    check("mode0_beats", mode_cnt[0], v.e_m0);
    check("mode1_beats", mode_cnt[1], v.e_m1);
    check("mode2_beats", mode_cnt[2], v.e_m2);
    check("mode3_beats", mode_cnt[3], v.e_m3);
    check("tbl_reads", tbl_rds, v.e_tbl);
    check("dat_reads", dat_rds, v.e_m3);
    check("tbl_max_addr", max_addr, v.e_max);
    check("first_beat_latency",
          first_cyc - start_cyc, 3);
    if (v.early > 0)
      check("early_results_done",
            done_cyc - last_xfer_cyc, 1);
    mon_on = 1'b0;
    pct = 100;
  endtask

  vec_t vecs [8];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 11, 2874, 100, 0, 0,
                11, 11, 22, 2874, 44, 'h215};
    vecs[1] = '{1, 11, 2874, 30, 0, 0,
                11, 11, 22, 2874, 44, 'h215};
    vecs[2] = '{0, 11, 5, 100, 0, 0,
                0, 0, 0, 5, 0, 0};
    vecs[3] = '{1, 1, 0, 100, 0, 0,
                1, 1, 2, 0, 4, 'h201};
    vecs[4] = '{0, 9, 40, 60, 15, 0,
                0, 0, 0, 40, 0, 0};
    vecs[5] = '{1, 255, 3, 100, 0, 0,
                255, 255, 510, 3, 1020, 'h3FD};
    vecs[6] = '{1, 4, 3, 100, 0, 4,
                4, 4, 8, 3, 16, 'h207};
    vecs[7] = '{1, 2, 3, 100, 0, 0,
                2, 2, 4, 3, 8, 'h203};
    for (int i = 0; i < 1024; i++)
      tbl_mem[i] = 8'($urandom);

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", dec_if.dec_valid, 0);
    check("rst_rd_en", {tbl_rd_en, dat_rd_en}, 0);
    check("rst_addr", {tbl_addr, dat_addr}, 0);
    check("rst_payload",
          {dec_if.dec_mode, dec_if.dec_data,
           dec_if.dec_id}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 7; k++) run(vecs[k]);

    @(negedge clk);
    cfg_load_tables = 1'b0;
    cfg_num_data = 12'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("pre_reset_active",
          {dec_if.dec_valid, dat_rd_en, busy}, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", dec_if.dec_valid, 0);
    check("async_rst_rd",
          {tbl_rd_en, dat_rd_en, tbl_addr, dat_addr}, 0);
    check("async_rst_payload",
          {dec_if.dec_mode, dec_if.dec_data,
           dec_if.dec_id}, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(vecs[7]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
